// File: rtl/wb_slot_scheduler_pkg.sv
// Shared constants and types for the writeback slot scheduler.
// Bus ids, ring depth and latency width are fixed here so the ring and the top agree.
package wb_sched_pkg;

   localparam int NUM_REQ   = 2;
   localparam int NUM_WB    = 2;
   localparam int HORIZON   = 32;
   localparam int LAT_W     = 5;
   localparam int WB_IDX_W  = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
   localparam int NUM_CLAIM = NUM_REQ + 1;
   localparam int CNT_W     = $clog2(NUM_REQ + 1);
   localparam int MUL_LAT   = 9;
   localparam int MUL_WB    = 1;
   localparam int DIV_WB    = 1;

   typedef logic [LAT_W-1:0]    lat_t;
   typedef logic [WB_IDX_W-1:0] wb_idx_t;

   typedef enum logic {
      DIV_IDLE = 1'b0,
      DIV_BUSY = 1'b1
   } div_state_e;

   function automatic logic lat_legal(input lat_t lat);
      return (lat != '0) && (int'(lat) < HORIZON);
   endfunction

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CNT_W-1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, a} + 17'(inc);
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/wb_slot_scheduler_if.sv
// Issue/writeback handshake bundle between reservation station, divider and scheduler.
// Statistics outputs exist only when WB_SCHED_STATS_EN is defined.
interface wb_slot_scheduler_if;
   import wb_sched_pkg::*;

   logic    [NUM_REQ-1:0] IN_req;
   wb_idx_t [NUM_REQ-1:0] IN_reqWB;
   lat_t    [NUM_REQ-1:0] IN_reqLat;
   logic    [NUM_REQ-1:0] IN_reqIsDiv;
   logic                  IN_divDone;

   logic    [NUM_REQ-1:0] OUT_grant;
   logic                  OUT_divWbGrant;
   logic                  OUT_MUL_doNotIssue;
   logic                  OUT_DIV_doNotIssue;
   logic    [NUM_WB-1:0]  OUT_slotBusy;

`ifdef WB_SCHED_STATS_EN
   logic [15:0] OUT_statConflict;
   logic [15:0] OUT_statDivStall;

   modport master (
      output IN_req, IN_reqWB, IN_reqLat, IN_reqIsDiv, IN_divDone,
      input  OUT_grant, OUT_divWbGrant, OUT_MUL_doNotIssue, OUT_DIV_doNotIssue, OUT_slotBusy,
      input  OUT_statConflict, OUT_statDivStall
   );

   modport slave (
      input  IN_req, IN_reqWB, IN_reqLat, IN_reqIsDiv, IN_divDone,
      output OUT_grant, OUT_divWbGrant, OUT_MUL_doNotIssue, OUT_DIV_doNotIssue, OUT_slotBusy,
      output OUT_statConflict, OUT_statDivStall
   );
`else
   modport master (
      output IN_req, IN_reqWB, IN_reqLat, IN_reqIsDiv, IN_divDone,
      input  OUT_grant, OUT_divWbGrant, OUT_MUL_doNotIssue, OUT_DIV_doNotIssue, OUT_slotBusy
   );

   modport slave (
      input  IN_req, IN_reqWB, IN_reqLat, IN_reqIsDiv, IN_divDone,
      output OUT_grant, OUT_divWbGrant, OUT_MUL_doNotIssue, OUT_DIV_doNotIssue, OUT_slotBusy
   );
`endif

endinterface

// File: rtl/wb_slot_scheduler_ring.sv
// Reservation ring for one result bus: bit k set means the bus is driven k cycles after now.
// Claimants past index NUM_REQ-1 are internal (divider writeback) and are never queried.
module wb_slot_ring
   import wb_sched_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_CLAIM-1:0] claim_vld,
   input  lat_t [NUM_CLAIM-1:0] claim_lat,
   output logic [NUM_REQ-1:0]   query_free,
   output logic                 slot_busy,
   output logic                 mul_peek
);

   logic [HORIZON-1:0] resv_q;
   logic [HORIZON-1:0] resv_d;
   logic [HORIZON-1:0] claim_mask;

   // A claim at latency L lands at L-1 because the whole ring shifts by one on the same edge.
   always_comb begin
      claim_mask = '0;
      for (int j = 0; j < NUM_CLAIM; j++) begin
         if (claim_vld[j] && lat_legal(claim_lat[j])) begin
            claim_mask[claim_lat[j] - lat_t'(1)] = 1'b1;
         end
      end
      resv_d = (resv_q >> 1) | claim_mask;

      query_free = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         query_free[i] = !resv_q[claim_lat[i]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resv_q <= '0;
      end else begin
         resv_q <= resv_d;
      end
   end

   assign slot_busy = resv_q[1];
   assign mul_peek  = resv_q[MUL_LAT];

endmodule

// File: rtl/wb_slot_scheduler.sv
// Result-bus slot arbiter: books future writeback cycles per bus and tracks divider occupancy.
// Optional saturating statistics counters are built when WB_SCHED_STATS_EN is defined.
//
//  state    | meaning
//  DIV_IDLE | divider free, a div request may be granted
//  DIV_BUSY | divide in flight, released by a granted divDone
module wb_slot_scheduler
   import wb_sched_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   wb_slot_scheduler_if.slave  bus
);

   localparam logic [NUM_WB-1:0] MUL_MASK = NUM_WB'(1) << MUL_WB;

   div_state_e div_state_q;
   div_state_e div_state_d;

   logic [NUM_WB-1:0][NUM_CLAIM-1:0] ring_claim_vld;
   lat_t [NUM_CLAIM-1:0]             ring_claim_lat;
   logic [NUM_WB-1:0][NUM_REQ-1:0]   ring_free;
   logic [NUM_WB-1:0]                ring_busy;
   logic [NUM_WB-1:0]                ring_peek;

   logic [NUM_REQ-1:0] fixed_grant;
   logic [NUM_REQ-1:0] div_grant;
   logic               div_taken;
   logic               same_slot;
   logic               port_on_div_slot1;
   logic               div_wb_grant;

   for (genvar b = 0; b < NUM_WB; b++) begin : g_ring
      wb_slot_ring u_ring (
         .clk        (clk),
         .rst        (rst),
         .claim_vld  (ring_claim_vld[b]),
         .claim_lat  (ring_claim_lat),
         .query_free (ring_free[b]),
         .slot_busy  (ring_busy[b]),
         .mul_peek   (ring_peek[b])
      );
   end

   // Requesters are scanned in priority order; a slot taken by a lower index is no longer free.
   always_comb begin
      fixed_grant       = '0;
      div_grant         = '0;
      div_taken         = 1'b0;
      same_slot         = 1'b0;
      port_on_div_slot1 = 1'b0;

      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.IN_req[i]) begin
            if (bus.IN_reqIsDiv[i]) begin
               if ((div_state_q == DIV_IDLE) && !div_taken) begin
                  div_grant[i] = 1'b1;
                  div_taken    = 1'b1;
               end
            end else if (lat_legal(bus.IN_reqLat[i]) && ring_free[bus.IN_reqWB[i]][i]) begin
               same_slot = 1'b0;
               for (int k = 0; k < NUM_REQ; k++) begin
                  if ((k < i) && fixed_grant[k] &&
                      (bus.IN_reqWB[k] == bus.IN_reqWB[i]) &&
                      (bus.IN_reqLat[k] == bus.IN_reqLat[i])) begin
                     same_slot = 1'b1;
                  end
               end
               fixed_grant[i] = !same_slot;
            end
         end
      end

      for (int i = 0; i < NUM_REQ; i++) begin
         if (fixed_grant[i] && (bus.IN_reqWB[i] == wb_idx_t'(DIV_WB)) &&
             (bus.IN_reqLat[i] == lat_t'(1))) begin
            port_on_div_slot1 = 1'b1;
         end
      end

      div_wb_grant = bus.IN_divDone && !ring_busy[DIV_WB] && !port_on_div_slot1;
   end

   always_comb begin
      ring_claim_vld = '0;
      ring_claim_lat = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ring_claim_lat[i] = bus.IN_reqLat[i];
      end
      ring_claim_lat[NUM_REQ] = lat_t'(1);

      for (int b = 0; b < NUM_WB; b++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            ring_claim_vld[b][i] = fixed_grant[i] && (bus.IN_reqWB[i] == wb_idx_t'(b));
         end
         ring_claim_vld[b][NUM_REQ] = div_wb_grant && (b == DIV_WB);
      end
   end

   always_comb begin
      div_state_d = div_state_q;
      case (div_state_q)
         DIV_IDLE: if (|div_grant)   div_state_d = DIV_BUSY;
         DIV_BUSY: if (div_wb_grant) div_state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_state_q <= DIV_IDLE;
      end else begin
         div_state_q <= div_state_d;
      end
   end

   // Combinational grants are forced low during reset so nothing is accepted mid-reset.
   assign bus.OUT_grant          = rst ? '0 : (fixed_grant | div_grant);
   assign bus.OUT_divWbGrant     = rst ? 1'b0 : div_wb_grant;
   assign bus.OUT_MUL_doNotIssue = |(ring_peek & MUL_MASK);
   assign bus.OUT_DIV_doNotIssue = (div_state_q == DIV_BUSY);
   assign bus.OUT_slotBusy       = ring_busy;

`ifdef WB_SCHED_STATS_EN
   logic [CNT_W-1:0] conflict_cnt;
   logic [CNT_W-1:0] stall_cnt;
   logic [15:0]      stat_conflict_q;
   logic [15:0]      stat_conflict_d;
   logic [15:0]      stat_stall_q;
   logic [15:0]      stat_stall_d;

   // Illegal latencies are neither conflicts nor stalls; they are simply refused.
   always_comb begin
      conflict_cnt = '0;
      stall_cnt    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.IN_req[i] && !fixed_grant[i] && !div_grant[i]) begin
            if (bus.IN_reqIsDiv[i]) begin
               if (div_state_q == DIV_BUSY) begin
                  stall_cnt = stall_cnt + CNT_W'(1);
               end else begin
                  conflict_cnt = conflict_cnt + CNT_W'(1);
               end
            end else if (lat_legal(bus.IN_reqLat[i])) begin
               conflict_cnt = conflict_cnt + CNT_W'(1);
            end
         end
      end
      stat_conflict_d = sat_add16(stat_conflict_q, conflict_cnt);
      stat_stall_d    = sat_add16(stat_stall_q, stall_cnt);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_conflict_q <= '0;
         stat_stall_q    <= '0;
      end else begin
         stat_conflict_q <= stat_conflict_d;
         stat_stall_q    <= stat_stall_d;
      end
   end

   assign bus.OUT_statConflict = stat_conflict_q;
   assign bus.OUT_statDivStall = stat_stall_q;
`endif

endmodule

// File: tb/tb_wb_slot_scheduler.sv
// Scoreboard bench for wb_slot_scheduler: the reference books absolute bus cycles
// (cycle number + latency) and a monitor compares every cycle's outputs against it.
module tb_wb_slot_scheduler;
   import wb_sched_pkg::*;

   localparam int MAXC = 8192;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_slot_scheduler_if bus();

   wb_slot_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [NUM_REQ-1:0] grant;
      logic               dwg;
      logic               mdni;
      logic               ddni;
      logic [NUM_WB-1:0]  busy;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   bit   booked [NUM_WB][MAXC];
   bit   div_busy = 1'b0;
   int   t = 0;

   logic div_pending = 1'b0;
   int   div_cnt = 0;

   function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0d: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   initial begin
      bus.IN_req      = '0;
      bus.IN_reqWB    = '0;
      bus.IN_reqLat   = '0;
      bus.IN_reqIsDiv = '0;
      bus.IN_divDone  = 1'b0;
   end

   // One cycle of stimulus; the expectation is the bus-cycle booking view of the rules.
   task automatic step(input bit r, input logic [1:0] req, input logic [1:0] isdiv,
                       input logic [1:0] wb, input logic [4:0] l0, input logic [4:0] l1,
                       input logic done);
      exp_t e;
      int   lat [2];
      bit   dtaken;
      @(posedge clk);
      #1;
      rst             = r;
      bus.IN_req      = req;
      bus.IN_reqIsDiv = isdiv;
      bus.IN_reqWB[0] = wb[0];
      bus.IN_reqWB[1] = wb[1];
      bus.IN_reqLat[0] = l0;
      bus.IN_reqLat[1] = l1;
      bus.IN_divDone  = done;
      lat[0] = int'(l0);
      lat[1] = int'(l1);
      e = '0;
      if (r) begin
         for (int b = 0; b < NUM_WB; b++)
            for (int c = 0; c < MAXC; c++) booked[b][c] = 1'b0;
         div_busy = 1'b0;
      end else begin
         e.mdni = booked[MUL_WB][t + MUL_LAT];
         e.ddni = div_busy;
         for (int b = 0; b < NUM_WB; b++) e.busy[b] = booked[b][t + 1];
         dtaken = 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
               if (isdiv[i]) begin
                  if (!div_busy && !dtaken) begin
                     e.grant[i] = 1'b1;
                     dtaken = 1'b1;
                  end
               end else if (lat[i] >= 1 && lat[i] <= HORIZON - 1 &&
                            !booked[int'(wb[i])][t + lat[i]]) begin
                  e.grant[i] = 1'b1;
                  booked[int'(wb[i])][t + lat[i]] = 1'b1;
               end
            end
         end
         e.dwg = done && !booked[DIV_WB][t + 1];
         if (e.dwg) booked[DIV_WB][t + 1] = 1'b1;
         if (dtaken) div_busy = 1'b1;
         else if (e.dwg) div_busy = 1'b0;
      end
      sb.push_back(e);
      t++;
   endtask

   task automatic idle();
      step(1'b0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 1'b0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("grant",      8'(bus.OUT_grant),          8'(e.grant));
            chk("divWbGrant", 8'(bus.OUT_divWbGrant),     8'(e.dwg));
            chk("mulDNI",     8'(bus.OUT_MUL_doNotIssue), 8'(e.mdni));
            chk("divDNI",     8'(bus.OUT_DIV_doNotIssue), 8'(e.ddni));
            chk("slotBusy",   8'(bus.OUT_slotBusy),       8'(e.busy));
         end
      end
   end

   initial begin : stim
      logic [1:0] rq, dv, wbs;
      logic [4:0] la, lb;
      logic [4:0] lats [2];
      repeat (3) step(1'b1, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 1'b0);

      // same target cycle from consecutive requests
      step(1'b0, 2'b01, 2'b00, 2'b00, 5'd3, 5'd0, 1'b0);
      step(1'b0, 2'b10, 2'b00, 2'b00, 5'd0, 5'd2, 1'b0);
      // same-cycle collision then retry
      step(1'b0, 2'b11, 2'b00, 2'b11, 5'd4, 5'd4, 1'b0);
      step(1'b0, 2'b10, 2'b00, 2'b10, 5'd0, 5'd4, 1'b0);
      // multiplier slot visibility
      step(1'b0, 2'b01, 2'b00, 2'b01, 5'(MUL_LAT + 1), 5'd0, 1'b0);
      repeat (3) idle();
      // divider: start, booked writeback slot, retry
      step(1'b0, 2'b01, 2'b01, 2'b00, 5'd0, 5'd0, 1'b0);
      step(1'b0, 2'b01, 2'b00, 2'b01, 5'd2, 5'd0, 1'b0);
      step(1'b0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 1'b1);
      step(1'b0, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 1'b1);
      repeat (2) idle();
      // illegal and extreme latencies
      step(1'b0, 2'b11, 2'b00, 2'b10, 5'd0, 5'd0, 1'b0);
      step(1'b0, 2'b01, 2'b00, 2'b00, 5'd31, 5'd0, 1'b0);
      repeat (2) idle();
      // reset mid-divide with several bookings
      step(1'b0, 2'b11, 2'b00, 2'b10, 5'd5, 5'd6, 1'b0);
      step(1'b0, 2'b11, 2'b00, 2'b01, 5'd7, 5'd8, 1'b0);
      step(1'b0, 2'b11, 2'b10, 2'b00, 5'd2, 5'd0, 1'b0);
      step(1'b1, 2'b11, 2'b00, 2'b00, 5'd1, 5'd1, 1'b1);
      step(1'b1, 2'b11, 2'b00, 2'b11, 5'd1, 5'd1, 1'b0);
      repeat (10) idle();

      div_pending = 1'b0;
      for (int n = 0; n < 2500; n++) begin
         rq  = 2'($urandom_range(0, 3));
         dv  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
         wbs = 2'($urandom_range(0, 3));
         for (int p = 0; p < 2; p++) begin
            case ($urandom_range(0, 9))
               0:       lats[p] = 5'd0;
               1, 2:    lats[p] = 5'($urandom_range(1, 31));
               3:       lats[p] = 5'(MUL_LAT + 1);
               default: lats[p] = 5'($urandom_range(1, 6));
            endcase
         end
         la = lats[0];
         lb = lats[1];
         if ($urandom_range(0, 499) == 0) begin
            step(1'b1, rq, dv, wbs, la, lb, div_pending);
         end else begin
            step(1'b0, rq, dv, wbs, la, lb, div_pending);
         end
         if (!div_busy) begin
            div_pending = 1'b0;
            div_cnt = $urandom_range(0, 8);
         end else if (!div_pending) begin
            if (div_cnt == 0) div_pending = 1'b1;
            else div_cnt--;
         end
      end

      repeat (2) idle();
      repeat (3) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
